// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// MEM/WB pipeline register. It sits directly after the data-memory stage,
// captures the memory-stage result word with its destination register and
// write enable, and drives the register-file write port one cycle later.
// It also produces the EX-stage operand forwarding selects and keeps a
// retired-instruction counter for debug and performance monitoring.
//
// Parameters
//   DATA_W      width of the result word and PC
//   REG_ADDR_W  register-file address width
//   CNT_W       retired-instruction counter width (wraps, no saturation)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   Stall         hold WB register contents this cycle
//   Flush         insert a bubble into WB this cycle (wins over Stall)
//   InValid       MEM-stage slot holds a real instruction
//   DataIn        MEM-stage result word
//   PCIn          PC of the MEM-stage instruction
//   WriteRegIn    MEM-stage destination register
//   RegWriteIn    MEM-stage register write enable
//   RsEx, RtEx    EX-stage source registers A and B
//   WriteData     registered result to the register file
//   WriteReg      registered destination register
//   RegWrite      registered register-file write enable
//   Valid         WB slot holds a real instruction
//   PCOut         registered PC (trace/debug)
//   ForwardA/B    EX operand select: 00 regfile, 10 MEM, 01 WB
//   RetiredCount  number of instructions accepted into WB
// ---------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic [DATA_W-1:0]     DataIn,
    input  logic [DATA_W-1:0]     PCIn,
    input  logic [REG_ADDR_W-1:0] WriteRegIn,
    input  logic                  RegWriteIn,
    input  logic [REG_ADDR_W-1:0] RsEx,
    input  logic [REG_ADDR_W-1:0] RtEx,
    output logic [DATA_W-1:0]     WriteData,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic                  RegWrite,
    output logic                  Valid,
    output logic [DATA_W-1:0]     PCOut,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic [CNT_W-1:0]      RetiredCount
);

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] wreg_q,  wreg_d;
    logic                  regwrite_q, regwrite_d;
    logic                  valid_q, valid_d;
    logic [DATA_W-1:0]     pc_q,    pc_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    // The MEM-stage instruction really writes the register file only when
    // it is valid, enabled and not targeting the hard-wired zero register.
    // The same term gates both the captured RegWrite and the MEM forward hit.
    logic mem_writes;
    assign mem_writes = RegWriteIn & InValid & (WriteRegIn != '0);

    // Flush has priority over Stall; reset is handled in the register block.
    always_comb begin
        wdata_d    = wdata_q;
        wreg_d     = wreg_q;
        regwrite_d = regwrite_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        if (Flush) begin
            wdata_d    = '0;
            wreg_d     = '0;
            regwrite_d = 1'b0;
            valid_d    = 1'b0;
            pc_d       = '0;
        end else if (!Stall) begin
            wdata_d    = DataIn;
            wreg_d     = WriteRegIn;
            regwrite_d = mem_writes;
            valid_d    = InValid;
            pc_d       = PCIn;
            if (InValid) begin
                cnt_d = cnt_q + CNT_W'(1);   // wraps naturally
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q    <= '0;
            wreg_q     <= '0;
            regwrite_q <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            cnt_q      <= '0;
        end else begin
            wdata_q    <= wdata_d;
            wreg_q     <= wreg_d;
            regwrite_q <= regwrite_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign WriteData    = wdata_q;
    assign WriteReg     = wreg_q;
    assign RegWrite     = regwrite_q;
    assign Valid        = valid_q;
    assign PCOut        = pc_q;
    assign RetiredCount = cnt_q;

    // ------------------------------------------------------------------
    // Forwarding selects, one identical slice per EX source operand.
    // MEM holds the younger instruction, so its hit is checked first.
    // The WB hit uses the registered state, so it is stable under Stall.
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] src_reg [2];
    assign src_reg[0] = RsEx;
    assign src_reg[1] = RtEx;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [1:0] sel;
        always_comb begin
            sel = 2'b00;
            if (src_reg[gi] != '0) begin
                if (mem_writes && (WriteRegIn == src_reg[gi])) begin
                    sel = 2'b10;
                end else if (regwrite_q && (wreg_q == src_reg[gi])) begin
                    sel = 2'b01;
                end
            end
        end
    end

    assign ForwardA = g_fwd[0].sel;
    assign ForwardB = g_fwd[1].sel;

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register that sits directly downstream of the data-memory stage.
- Captures the memory-stage result word (load data, lui field or ALU address) with its destination register and write-enable, and presents them to the register-file write port.
- Also produces EX-stage forwarding selects from MEM- and WB-stage destinations.
- Keeps a retired-instruction counter for debug/perf.

Parameters:
- DATA_W, 32, width of result word and PC.
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, retired-instruction counter width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- Stall  input  1  hold WB register contents this cycle.
- Flush  input  1  insert bubble into WB this cycle.
- InValid  input  1  MEM-stage slot holds a real instruction.
- DataIn  input  DATA_W  MEM-stage result word (memory DataOut).
- PCIn  input  DATA_W  PC of MEM-stage instruction.
- WriteRegIn  input  REG_ADDR_W  MEM-stage destination register.
- RegWriteIn  input  1  MEM-stage register write enable.
- RsEx  input  REG_ADDR_W  EX-stage source register A.
- RtEx  input  REG_ADDR_W  EX-stage source register B.
- WriteData  output  DATA_W  registered result to register file.
- WriteReg  output  REG_ADDR_W  registered destination register.
- RegWrite  output  1  registered register-file write enable.
- Valid  output  1  WB slot holds a real instruction.
- PCOut  output  DATA_W  registered PC (trace/debug).
- ForwardA  output  2  EX operand A select: 00 regfile, 10 MEM (DataIn), 01 WB (WriteData).
- ForwardB  output  2  same encoding for operand B.
- RetiredCount  output  CNT_W  count of instructions accepted into WB.

Behaviour:
- All state updates on rising clk. Priority: reset > Flush > Stall > capture.
- Reset (synchronous):
  - WriteData=0, WriteReg=0, RegWrite=0, Valid=0, PCOut=0, RetiredCount=0.
  - Reset asserted mid-operation discards the in-flight slot; no write is issued in the following cycle.
- Flush (reset=0):
  - Bubble: Valid=0, RegWrite=0, WriteReg=0, WriteData=0, PCOut=0.
  - RetiredCount unchanged.
  - Flush wins over simultaneous Stall.
- Stall (reset=0, Flush=0): all registers hold; RetiredCount unchanged.
- Capture (otherwise):
  - WriteData<=DataIn, PCOut<=PCIn, WriteReg<=WriteRegIn, Valid<=InValid.
  - RegWrite<=RegWriteIn & InValid & (WriteRegIn!=0). A register-0 write is never issued.
  - If InValid=1, RetiredCount<=RetiredCount+1, wrapping modulo 2^CNT_W. No saturation and no flag on wrap.
- Latency: one cycle from MEM-stage inputs to WB outputs.
- Forwarding logic is combinational; evaluate A and B independently:
  - MEM hit: RegWriteIn & InValid & WriteRegIn!=0 & WriteRegIn==RsEx gives ForwardA=10.
  - Otherwise WB hit: RegWrite & WriteReg==RsEx gives ForwardA=01.
  - Otherwise ForwardA=00.
  - ForwardB is identical, using RtEx.
  - When both stages match, MEM (the younger instruction) takes priority.
  - RsEx/RtEx=0 always yields 00, because register 0 is excluded in both hit terms.
  - During reset, RegWrite=0, so the WB path never hits.
- Forwarding reflects current register contents, so under Stall the WB hit stays stable.
- No X-propagation: every output is driven from reset onward.

Test Plan:
- Reset then capture: reset 2 cycles, then DataIn=0x0000_00AB, WriteRegIn=5, RegWriteIn=1, InValid=1 -> next cycle WriteData=0xAB, WriteReg=5, RegWrite=1, Valid=1, RetiredCount=1.
- Reg-zero suppression: capture WriteRegIn=0, RegWriteIn=1, InValid=1 -> RegWrite=0, Valid=1, RetiredCount increments; RsEx=0 -> ForwardA=00.
- Stall/flush priority:
  - Load slot with 0x1234 to r7, then Stall=1 for 3 cycles while inputs change -> outputs stay 0x1234/r7.
  - Then Stall=1 and Flush=1 together -> Valid=0, RegWrite=0, WriteData=0; RetiredCount unchanged.
- Forwarding priority:
  - WB holds r9 (RegWrite=1) and MEM inputs r9, RegWriteIn=1, InValid=1, with RsEx=9, RtEx=9 -> ForwardA=ForwardB=10.
  - Drop InValid -> both become 01.
  - RtEx=3 -> ForwardB=00.
- Counter wrap: force RetiredCount to 0xFFFF_FFFF (or CNT_W=4 at 0xF), capture a valid slot -> count=0. An invalid capture leaves the count unchanged.
- Reset mid-stream: valid write to r4 in WB, assert reset for 1 cycle -> next cycle RegWrite=0, Valid=0, all outputs 0, ForwardA/B=00 for RsEx=4.
